// File: rtl/jesd_bringup_seq.sv
// JESD204C link bring-up sequencer: drives converter reset, rx/tx enables and the
// clock-chip sync pulse, then waits for a synchronized link-up with timeout and retry.
module jesd_bringup_seq #(
    parameter int RST_CYCLES    = 1000,
    parameter int SETTLE_CYCLES = 10000,
    parameter int SYNC_CYCLES   = 16,
    parameter int LOCK_CYCLES   = 256,
    parameter int LINK_TIMEOUT  = 1000000,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 24
) (
    input  logic       axil_aclk,
    input  logic       axil_areset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       link_up,
    output logic       rstb,
    output logic [1:0] rxen,
    output logic [1:0] txen,
    output logic       hmc_sync,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retry_cnt
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [CNT_W-1:0]  C_RST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_SYNC    = CNT_W'(SYNC_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_TIMEOUT = CNT_W'(LINK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE = CNT_W'(1);
    localparam logic [LOCK_W-1:0] C_LOCK    = LOCK_W'(LOCK_CYCLES);
    localparam logic [LOCK_W-1:0] C_LK_ONE  = LOCK_W'(1);
    localparam logic [3:0]        C_MAXR    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_SETTLE    = 3'd2,
        S_ENABLE    = 3'd3,
        S_SYNC      = 3'd4,
        S_WAIT_LINK = 3'd5,
        S_RUNNING   = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [LOCK_W-1:0]   r_lock;
    logic [LOCK_W-1:0]   w_lock_next;
    logic [LOCK_W-1:0]   w_lock_inc;
    logic [3:0]          r_retry;
    logic [3:0]          w_retry_next;
    logic                w_do_retry;
    logic                r_link_meta;
    logic                r_link_s;

    logic                r_rstb;
    logic [1:0]          r_en;
    logic                r_hmc_sync;
    logic                r_busy;
    logic                r_done;
    logic                r_fault;
    logic                w_rstb;
    logic [1:0]          w_en;
    logic                w_hmc_sync;
    logic                w_busy;
    logic                w_done;
    logic                w_fault;

    // link_up arrives from the link_clk domain; only the second flop is used for decisions.
    always_ff @(posedge axil_aclk or negedge axil_areset_n) begin
        if (!axil_areset_n) begin
            r_link_meta <= 1'b0;
            r_link_s    <= 1'b0;
        end else begin
            r_link_meta <= link_up;
            r_link_s    <= r_link_meta;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_lock_next  = r_lock;
        w_retry_next = r_retry;
        w_do_retry   = 1'b0;
        w_lock_inc   = '0;

        case (r_state)
            S_IDLE, S_FAULT: begin
                if (start) begin
                    w_state_next = S_RESET;
                    w_cnt_next   = C_RST;
                    w_retry_next = '0;
                end
            end
            S_RESET: begin
                if (r_cnt == '0) begin
                    w_state_next = S_SETTLE;
                    w_cnt_next   = C_SETTLE;
                end else begin
                    w_cnt_next = r_cnt - C_CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_next = S_ENABLE;
                end else begin
                    w_cnt_next = r_cnt - C_CNT_ONE;
                end
            end
            S_ENABLE: begin
                w_state_next = S_SYNC;
                w_cnt_next   = C_SYNC;
            end
            S_SYNC: begin
                if (r_cnt == '0) begin
                    w_state_next = S_WAIT_LINK;
                    w_cnt_next   = C_TIMEOUT;
                    w_lock_next  = '0;
                end else begin
                    w_cnt_next = r_cnt - C_CNT_ONE;
                end
            end
            S_WAIT_LINK: begin
                // A lock completing on the timeout cycle still counts as a lock.
                if (r_link_s) begin
                    w_lock_inc = (r_lock == C_LOCK) ? r_lock : r_lock + C_LK_ONE;
                end
                w_lock_next = w_lock_inc;
                if (w_lock_inc == C_LOCK) begin
                    w_state_next = S_RUNNING;
                end else if (r_cnt == '0) begin
                    w_do_retry = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - C_CNT_ONE;
                end
            end
            S_RUNNING: begin
                if (!r_link_s) begin
                    w_do_retry = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_do_retry) begin
            if (r_retry < C_MAXR) begin
                w_retry_next = r_retry + 4'd1;
                w_state_next = S_RESET;
                w_cnt_next   = C_RST;
            end else begin
                w_state_next = S_FAULT;
            end
        end

        if (abort) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_lock_next  = '0;
            w_retry_next = r_retry;
        end
    end

    // Outputs are decoded from the next state so they register in step with r_state.
    always_comb begin
        w_rstb     = 1'b0;
        w_en       = 2'b00;
        w_hmc_sync = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_fault    = 1'b0;
        case (w_state_next)
            S_RESET: begin
                w_busy = 1'b1;
            end
            S_SETTLE: begin
                w_rstb = 1'b1;
                w_busy = 1'b1;
            end
            S_ENABLE, S_WAIT_LINK: begin
                w_rstb = 1'b1;
                w_en   = 2'b11;
                w_busy = 1'b1;
            end
            S_SYNC: begin
                w_rstb     = 1'b1;
                w_en       = 2'b11;
                w_hmc_sync = 1'b1;
                w_busy     = 1'b1;
            end
            S_RUNNING: begin
                w_rstb = 1'b1;
                w_en   = 2'b11;
                w_done = 1'b1;
            end
            S_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                w_rstb = 1'b0;
            end
        endcase
    end

    always_ff @(posedge axil_aclk or negedge axil_areset_n) begin
        if (!axil_areset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lock     <= '0;
            r_retry    <= '0;
            r_rstb     <= 1'b0;
            r_en       <= 2'b00;
            r_hmc_sync <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_lock     <= w_lock_next;
            r_retry    <= w_retry_next;
            r_rstb     <= w_rstb;
            r_en       <= w_en;
            r_hmc_sync <= w_hmc_sync;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_fault    <= w_fault;
        end
    end

    assign rstb      = r_rstb;
    assign rxen      = r_en;
    assign txen      = r_en;
    assign hmc_sync  = r_hmc_sync;
    assign busy      = r_busy;
    assign done      = r_done;
    assign fault     = r_fault;
    assign state     = r_state;
    assign retry_cnt = r_retry;

endmodule
